unidec_sched: RTL and testbench
===============================

# unidec_sched

Deterministic scheduler for the unique-decipherability prefix/suffix datapath. It holds a code table of up to eight words and runs the Sardinas–Patterson dangling-suffix closure one comparison per clock. It maintains a visited suffix set that doubles as the BFS worklist, and reports whether the code is uniquely decipherable or ambiguous. It replaces the nondeterministic `sel1`/`sel2` exploration with an exhaustive, sequenced search that the verification flow can drive.

## Interface
- `DEPTH`, 32, number of entries in the suffix set/worklist (all suffixes of 8 words × 4 proper cut points).
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `ld_valid`  in  1  write `ld_word` into table entry `ld_idx`; ignored while `busy`.
- `ld_idx`  in  3  table index.
- `ld_word`  in  16  code word: 3-bit chars (a=0 … e=4), first char in bits [2:0], stop bit immediately above the last char.
- `num_words`  in  4  active entries 0..N-1; sampled on accepted `start`; values above 8 are treated as 8.
- `start`  in  1  begin a check; accepted only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse; result outputs are valid in this cycle and held until the next accepted `start`.
- `ambiguous`  out  1  code is not uniquely decipherable.
- `err`  out  1  malformed active word, or suffix set overflow.
- `witness`  out  16  see Configuration.

## Operation
- Word length L(w) is k when the only set bit above the chars is bit 3k (k = 0..5). Any other pattern is malformed.
- P(x,y), "x is a proper prefix of y": L(x) < L(y) and y[3L(x)-1:0] == x[3L(x)-1:0].
- Suffix S(x,y) = y >> 3L(x). The stop bit is preserved by the shift.
- FSM states: IDLE, CHECK, PAIRS, SCAN, DONE.
- IDLE: accepted `start` latches N and clears the set (head = tail = 0). Next state is CHECK if N > 0, else DONE with unique.
- CHECK: one cycle; tests all active entries combinationally.
  - Any word with L = 0 or malformed → DONE with `err` = 1.
  - Otherwise → PAIRS.
- PAIRS: one cycle per ordered pair (i,j), i outer, j inner, both over 0..N-1, skipping nothing.
  - i ≠ j and code[i] == code[j] → DONE with ambiguous.
  - P(code[i],code[j]) → insert S(code[i],code[j]).
  - After the last pair: DONE with unique if the set is empty, else SCAN.
- SCAN: s = set[head]; one cycle per j = 0..N-1.
  - s == code[j] → DONE with ambiguous.
  - P(code[j],s) → insert S(code[j],s).
  - P(s,code[j]) → insert S(s,code[j]).
  - After j = N-1: head++. If head == tail after the increment → DONE with unique.
- Insert: a combinational compare against all entries [0,tail) suppresses duplicates. At most one insert can occur per cycle.
- If an insert is needed with tail == DEPTH → DONE with `err` = 1 and `ambiguous` = 0.
- DONE: `done` = 1 for one cycle, then IDLE.
- The code table is writable only in IDLE/DONE. A write in the same cycle as an accepted `start` lands before the check.

## Timing
- Reset values: `busy`, `done`, `ambiguous`, `err` = 0 and `witness` = 0. The FSM goes to IDLE, head/tail are cleared, and every table entry is set to 16'h0000 (malformed).
- Reset asserted mid-check aborts the check; `done` is not pulsed.
- Latency from the accepted `start` edge at cycle 0:
  - CHECK occupies cycle 1.
  - PAIRS occupies cycles 2..N²+1.
  - Each SCAN entry takes N cycles.
  - `done` asserts the cycle after the terminating comparison.
- Early exit: detection of ambiguity or overflow skips the remaining comparisons.
- Worst case: 1 + 64 + 32·8 + 1 = 322 cycles after `start`.
- `start` while `busy` is ignored, with no queueing.

## Configuration
- `UNIDEC_WITNESS_EN` defined: on an ambiguous result, `witness` holds the colliding value (code[i] in PAIRS, s in SCAN), latched at detection and held until the next `start`.
- Not defined: `witness` is tied to 0 and no witness register is synthesized.

## Test plan
- Ash code, N=7:
  - Load a=0x0008, c=0x000A, ad=0x0058, abb=0x0248, bad=0x02C1, deb=0x0263, bbcde=0xC689, then `start`.
  - Required: `done` with `ambiguous` = 1, `err` = 0.
- Prefix code {a=0x0008, b=0x0009, c=0x000A}, N=3: `done` at cycle 11 with `ambiguous` = 0, `err` = 0, and the set stays empty.
- {a=0x0008, ab=0x0048, b=0x0009}, N=3:
  - PAIRS inserts b; SCAN matches b at j=2 in cycle 13.
  - Required: `done` at cycle 14 with `ambiguous` = 1; `witness` = 0x0009 when `UNIDEC_WITNESS_EN` is defined.
- Duplicate {0x0008, 0x0008}, N=2: `ambiguous` = 1 during PAIRS at pair (0,1); `done` at cycle 4.
- Entry 1 = 0x0010 (malformed), N=2: `done` at cycle 2 with `err` = 1.
- Corner cases:
  - `rst_n` low for one cycle mid-SCAN: all outputs 0 the next cycle, and no `done`.
  - A following `start` with the table reloaded rechecks correctly.
  - `start` while `busy`: no effect.

Source files
------------

// File: rtl/unidec_sched.sv
// unidec_sched
// Sequenced Sardinas-Patterson unique-decipherability checker. It holds a table
// of up to eight code words and runs the dangling-suffix closure one comparison
// per clock. A visited-suffix set doubles as the breadth-first worklist: head
// walks the entries still to be scanned, and tail is the insertion point.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   ld_valid   write ld_word into table entry ld_idx (IDLE/DONE only)
//   ld_idx     table index
//   ld_word    code word: 3-bit chars, first char in [2:0], stop bit above last
//   num_words  active entry count, sampled on an accepted start (clamped to 8)
//   start      begin a check (accepted in IDLE only)
//   busy       high from the cycle after an accepted start through DONE
//   done       one-cycle completion pulse
//   ambiguous  code is not uniquely decipherable
//   err        malformed active word, or suffix set overflow
//   witness    colliding value on an ambiguous result (optional)
//
// Build option: define UNIDEC_WITNESS_EN to keep the colliding value on
// `witness`; without it `witness` is constant 0 and no register exists for it.
module unidec_sched #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [2:0]  ld_idx,
    input  logic [15:0] ld_word,
    input  logic [3:0]  num_words,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ambiguous,
    output logic        err,
    output logic [15:0] witness
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PAIRS, S_SCAN, S_DONE} state_t;

    // Returns {valid, length}. A word of length k has exactly the value 1 left
    // after shifting out its k chars; nothing else is a well-formed word.
    function automatic logic [3:0] f_len(input logic [15:0] w);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 6; k++)
            if ((w >> (3 * k)) == 16'd1) r = {1'b1, 3'(k)};
        return r;
    endfunction

    function automatic logic f_prefix(input logic [15:0] x, input logic [15:0] y);
        logic [3:0]  lx;
        logic [3:0]  ly;
        logic [15:0] m;
        lx = f_len(x);
        ly = f_len(y);
        m  = (16'd1 << (3 * lx[2:0])) - 16'd1;
        return lx[3] && ly[3] && (lx[2:0] < ly[2:0]) && ((x & m) == (y & m));
    endfunction

    // Dropping the chars of x from the front of y; the stop bit moves with them.
    function automatic logic [15:0] f_suffix(input logic [15:0] x, input logic [15:0] y);
        logic [3:0] lx;
        lx = f_len(x);
        return y >> (3 * lx[2:0]);
    endfunction

    state_t      r_state;
    logic [15:0] r_code [8];
    logic [15:0] r_set  [DEPTH];
    logic [3:0]  r_n;
    logic [2:0]  r_i;
    logic [2:0]  r_j;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic        r_busy;
    logic        r_done;
    logic        r_amb;
    logic        r_err;

    logic [15:0] w_ci;
    logic [15:0] w_cj;
    logic [15:0] w_s;
    logic [15:0] w_cand;
    logic        w_eq;
    logic        w_ins;
    logic        w_need;
    logic        w_full;
    logic        w_last_i;
    logic        w_last_j;
    logic [7:0]  w_bad_v;
    logic        w_bad;
    logic [DEPTH-1:0] w_hit;
    logic        w_dup;
    logic [PW-1:0] w_tail_next;
    logic [3:0]  w_n_in;

    assign w_n_in = (num_words > 4'd8) ? 4'd8 : num_words;

    // Current comparison: PAIRS compares code[i] with code[j]; SCAN compares
    // the worklist entry s with code[j]. The two prefix directions are
    // mutually exclusive, so at most one candidate suffix exists per cycle.
    always_comb begin
        w_ci   = r_code[r_i];
        w_cj   = r_code[r_j];
        w_s    = r_set[r_head[AW-1:0]];
        w_eq   = 1'b0;
        w_ins  = 1'b0;
        w_cand = 16'd0;
        if (r_state == S_SCAN) begin
            w_eq = (w_s == w_cj);
            if (f_prefix(w_cj, w_s)) begin
                w_ins  = 1'b1;
                w_cand = f_suffix(w_cj, w_s);
            end else if (f_prefix(w_s, w_cj)) begin
                w_ins  = 1'b1;
                w_cand = f_suffix(w_s, w_cj);
            end
        end else begin
            w_eq = (r_i != r_j) && (w_ci == w_cj);
            if (f_prefix(w_ci, w_cj)) begin
                w_ins  = 1'b1;
                w_cand = f_suffix(w_ci, w_cj);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chk
            logic [3:0] w_l;
            assign w_l         = f_len(r_code[gi]);
            assign w_bad_v[gi] = (4'(gi) < r_n) && (!w_l[3] || (w_l[2:0] == 3'd0));
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_dup
            assign w_hit[gi] = (PW'(gi) < r_tail) && (r_set[gi] == w_cand);
        end
    endgenerate

    assign w_bad       = |w_bad_v;
    assign w_dup       = |w_hit;
    assign w_need      = w_ins && !w_dup && !w_eq;
    assign w_full      = (r_tail == PW'(DEPTH));
    assign w_last_i    = ({1'b0, r_i} == (r_n - 4'd1));
    assign w_last_j    = ({1'b0, r_j} == (r_n - 4'd1));
    assign w_tail_next = w_need ? (r_tail + PW'(1)) : r_tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= 4'd0;
            r_i     <= 3'd0;
            r_j     <= 3'd0;
            r_head  <= '0;
            r_tail  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_amb   <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 0; k < 8; k++) r_code[k] <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            if (ld_valid && (r_state == S_IDLE || r_state == S_DONE))
                r_code[ld_idx] <= ld_word;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= w_n_in;
                        r_i    <= 3'd0;
                        r_j    <= 3'd0;
                        r_head <= '0;
                        r_tail <= '0;
                        r_amb  <= 1'b0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (w_n_in == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_PAIRS;
                    end
                end
                S_PAIRS, S_SCAN: begin
                    if (w_eq) begin
                        r_amb   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_need && w_full) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (w_need) begin
                            r_set[r_tail[AW-1:0]] <= w_cand;
                            r_tail                <= w_tail_next;
                        end
                        if (!w_last_j) begin
                            r_j <= r_j + 3'd1;
                        end else if (r_state == S_PAIRS) begin
                            r_j <= 3'd0;
                            if (!w_last_i) begin
                                r_i <= r_i + 3'd1;
                            end else if (w_tail_next == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_SCAN;
                            end
                        end else begin
                            // Finished one worklist entry; an exhausted list means closure.
                            r_j    <= 3'd0;
                            r_head <= r_head + PW'(1);
                            if ((r_head + PW'(1)) == w_tail_next) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ambiguous = r_amb;
    assign err       = r_err;

`ifdef UNIDEC_WITNESS_EN
    logic [15:0] r_wit;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wit <= 16'd0;
        end else if (r_state == S_IDLE && start) begin
            r_wit <= 16'd0;
        end else if (r_state == S_PAIRS && w_eq) begin
            r_wit <= w_ci;
        end else if (r_state == S_SCAN && w_eq) begin
            r_wit <= w_s;
        end
    end
    assign witness = r_wit;
`else
    assign witness = 16'd0;
`endif

endmodule

// File: tb/tb_unidec_sched.sv
// Self-checking bench for unidec_sched. A queue-based model of the dangling
// suffix closure predicts the result and the completion cycle of every check;
// one negedge process compares busy/done every cycle and the result outputs
// from the done cycle on.
module tb_unidec_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [2:0]  ld_idx = 3'd0;
    logic [15:0] ld_word = 16'd0;
    logic [3:0]  num_words = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        ambiguous;
    logic        err;
    logic [15:0] witness;

    unidec_sched dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_idx(ld_idx),
        .ld_word(ld_word), .num_words(num_words), .start(start), .busy(busy),
        .done(done), .ambiguous(ambiguous), .err(err), .witness(witness)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int exp_cyc = 0;
    int exp_amb = 0;
    int exp_err = 0;
    int exp_wit = 0;
    logic [15:0] tb_code [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Length in chars, or -1 if the word is malformed: the highest set bit
    // must be the stop bit, sitting on a char boundary.
    function automatic int blen(input logic [15:0] w);
        int msb;
        msb = -1;
        for (int b = 0; b < 16; b++) if (w[b]) msb = b;
        if (msb < 0 || (msb % 3) != 0) return -1;
        return msb / 3;
    endfunction

    function automatic bit bprefix(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] tx;
        logic [15:0] ty;
        if (!(blen(x) < blen(y))) return 1'b0;
        for (int c = 0; c < blen(x); c++) begin
            tx = x >> (3 * c);
            ty = y >> (3 * c);
            if (tx[2:0] != ty[2:0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Breadth-first closure in the order the scheduler must follow; the done
    // cycle is two past the number of comparisons made (CHECK is cycle 1).
    task automatic model(input int n, output int m_cyc, output int m_amb, output int m_err,
                         output int m_wit, output int m_sz);
        logic [15:0] sq[$];
        logic [15:0] s;
        logic [15:0] cand;
        int nn;
        int comp;
        int head;
        bit have;
        bit seen;
        nn = (n > 8) ? 8 : n;
        comp = 0; m_amb = 0; m_err = 0; m_wit = 0; m_sz = 0;
        if (nn == 0) begin m_cyc = 1; return; end
        for (int k = 0; k < nn; k++)
            if (blen(tb_code[k]) <= 0) begin m_err = 1; m_cyc = 2; return; end
        for (int i = 0; i < nn; i++) begin
            for (int j = 0; j < nn; j++) begin
                comp++;
                if (i != j && tb_code[i] == tb_code[j]) begin
                    m_amb = 1; m_wit = int'(tb_code[i]); m_cyc = comp + 2; return;
                end
                if (bprefix(tb_code[i], tb_code[j])) begin
                    cand = tb_code[j] >> (3 * blen(tb_code[i]));
                    seen = 1'b0;
                    foreach (sq[q]) if (sq[q] == cand) seen = 1'b1;
                    if (!seen) begin
                        if (sq.size() == 32) begin m_err = 1; m_cyc = comp + 2; return; end
                        sq.push_back(cand);
                    end
                end
            end
        end
        head = 0;
        while (head < sq.size()) begin
            s = sq[head];
            for (int j = 0; j < nn; j++) begin
                comp++;
                if (s == tb_code[j]) begin
                    m_amb = 1; m_wit = int'(s); m_cyc = comp + 2; m_sz = sq.size(); return;
                end
                have = 1'b0;
                cand = 16'd0;
                if (bprefix(tb_code[j], s)) begin
                    have = 1'b1; cand = s >> (3 * blen(tb_code[j]));
                end else if (bprefix(s, tb_code[j])) begin
                    have = 1'b1; cand = tb_code[j] >> (3 * blen(s));
                end
                if (have) begin
                    seen = 1'b0;
                    foreach (sq[q]) if (sq[q] == cand) seen = 1'b1;
                    if (!seen) begin
                        if (sq.size() == 32) begin m_err = 1; m_cyc = comp + 2; return; end
                        sq.push_back(cand);
                    end
                end
            end
            head++;
        end
        m_sz = sq.size();
        m_cyc = comp + 2;
    endtask

    // Per-cycle compare process.
    always @(negedge clk) begin
        if (chk_en) begin
            cyc = cyc + 1;
            check("busy", {31'd0, busy}, {31'd0, (cyc <= exp_cyc)});
            check("done", {31'd0, done}, {31'd0, (cyc == exp_cyc)});
            if (cyc >= exp_cyc) begin
                check("ambiguous", {31'd0, ambiguous}, exp_amb);
                check("err", {31'd0, err}, exp_err);
                check("witness", {16'd0, witness}, exp_wit);
            end
        end
    end

    task automatic load(input int idx, input logic [15:0] w);
        @(negedge clk);
        ld_valid = 1'b1; ld_idx = 3'(idx); ld_word = w;
        @(posedge clk);
        #1 ld_valid = 1'b0;
        tb_code[idx] = w;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1; num_words = 4'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string name, input int n, input bit disturb,
                       input int lit_cyc, input int lit_amb, input int lit_err, input int lit_sz);
        int m_cyc, m_amb, m_err, m_wit, m_sz;
        model(n, m_cyc, m_amb, m_err, m_wit, m_sz);
        if (lit_cyc >= 0) check({name, "_model_cyc"}, m_cyc, lit_cyc);
        check({name, "_model_amb"}, m_amb, lit_amb);
        check({name, "_model_err"}, m_err, lit_err);
        if (lit_sz >= 0) check({name, "_model_setsz"}, m_sz, lit_sz);
        exp_cyc = m_cyc; exp_amb = m_amb; exp_err = m_err;
`ifdef UNIDEC_WITNESS_EN
        exp_wit = m_amb ? m_wit : 0;
`else
        exp_wit = 0;
`endif
        if (disturb) begin
            fork
                begin
                    repeat (3) @(posedge clk);
                    @(negedge clk);
                    start = 1'b1; num_words = 4'd2;
                    ld_valid = 1'b1; ld_idx = 3'd1; ld_word = 16'h0008;
                    @(posedge clk);
                    #1 start = 1'b0; ld_valid = 1'b0;
                end
            join_none
        end
        pulse_start(n);
        cyc = 0;
        chk_en = 1'b1;
        repeat (exp_cyc + 1) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("run %s n=%0d: want amb=%0d err=%0d done@%0d wit=%0h", name, n,
                 exp_amb, exp_err, exp_cyc, exp_wit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) tb_code[k] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_amb", {31'd0, ambiguous}, 0);
        check("reset_err", {31'd0, err}, 0);
        check("reset_wit", {16'd0, witness}, 0);
        rst_n = 1'b1;

        // Prefix code a, b, c.
        load(0, 16'h0008); load(1, 16'h0009); load(2, 16'h000A);
        run("prefix", 3, 1'b0, 11, 0, 0, 0);

        // Same table with a start and a table write attempted while busy.
        run("busy_start", 3, 1'b1, 11, 0, 0, 0);
        run("recheck", 3, 1'b0, 11, 0, 0, 0);

        // a, ab, b: suffix b found in PAIRS, matched in SCAN.
        load(0, 16'h0008); load(1, 16'h0048); load(2, 16'h0009);
        run("a_ab_b", 3, 1'b0, 14, 1, 0, 1);

        // Duplicate words.
        load(0, 16'h0008); load(1, 16'h0008);
        run("dup", 2, 1'b0, 4, 1, 0, -1);

        // Malformed entry 1.
        load(1, 16'h0010);
        run("malformed", 2, 1'b0, 2, 0, 1, -1);

        // Empty table is trivially unique.
        run("empty", 0, 1'b0, 1, 0, 0, 0);

        // Ash code.
        load(0, 16'h0008); load(1, 16'h000A); load(2, 16'h0058); load(3, 16'h0248);
        load(4, 16'h02C1); load(5, 16'h0263); load(6, 16'hC689);
        run("ash", 7, 1'b0, -1, 1, 0, -1);

        // Eight single-char words with num_words above 8 (clamped).
        for (int k = 0; k < 8; k++) load(k, 16'h0008 + 16'(k));
        run("clamp8", 9, 1'b0, 66, 0, 0, 0);

        // Reset in the middle of SCAN (cycle 12 of the a, ab, b check).
        load(0, 16'h0008); load(1, 16'h0048); load(2, 16'h0009);
        pulse_start(3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tb_code[k] = 16'h0000;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_amb", {31'd0, ambiguous}, 0);
        check("midrst_err", {31'd0, err}, 0);
        check("midrst_wit", {16'd0, witness}, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("midrst_nodone", {31'd0, done}, 0);
        end
        $display("run midrst: reset during SCAN, outputs cleared");

        // Table was cleared by reset; reload and recheck.
        load(0, 16'h0008); load(1, 16'h0048); load(2, 16'h0009);
        run("after_rst", 3, 1'b0, 14, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
